uart_frame_tx: RTL and testbench

Standalone buffered UART transmitter producing the team's serial frame: start bit 0, 8 data bits LSB-first, even-parity bit (XOR of data bits), and a stop bit at 1.
- Bytes are pushed from the processor/bus side into an internal FIFO and serialised at a programmable bit period.
- It is the sending end that feeds the controller's receive path.
- It runs on a single system clock; the bit timing comes from an internal clock-enable divider.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 42 ++++
 rtl/uart_frame_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width, line levels and the
// parity helper. The receive side imports the same package so both ends agree
// on the frame format.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Even parity: the returned bit makes the total count of ones over data plus
  // parity even.
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period clock-enable generator.
//   clock     : system clock
//   init_flag : asynchronous active-low reset
//   clear     : restart the count at 0 on the next edge (frame start)
//   run       : count only while a frame is on the line
//   tick      : high during the last cycle of each bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic init_flag,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_frame_tx.sv
// Buffered UART transmitter: bytes are queued in an inline FIFO and sent as
// start(0), 8 data bits LSB first, even parity, STOP_BITS stop bits (1).
//   clock      : system clock
//   init_flag  : asynchronous active-low reset
//   wr_en      : push request for wr_data
//   wr_data    : byte to enqueue
//   enable     : allows new frames to start; a running frame always completes
//   tx         : registered serial line, idle high
//   busy       : a frame is on the line
//   full/empty : FIFO occupancy flags
//   level      : FIFO occupancy
//   overflow   : one-cycle pulse when a push is dropped
//   frame_done : one-cycle pulse on the last cycle of the last stop bit
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                     clock,
  input  logic                     init_flag,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     enable,
  output logic                     tx,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

  // FIFO storage and control
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          overflow_q;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // Frame FSM
  uart_state_e   state_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [2:0]    bit_idx_q;
  logic          stop_idx_q;
  logic          tx_q;
  logic          busy_q;
  logic          tick;
  logic          frame_end;
  logic          can_start;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Full is judged on pre-edge level, so a same-cycle pop never frees a slot.
  assign push = wr_en && !full;

  assign frame_end = (state_q == ST_STOP) && (stop_idx_q == STOP_LAST) && tick;
  assign can_start = enable && !empty;
  // Pop either from idle or on the final stop edge, giving zero idle gap.
  assign pop       = can_start && ((state_q == ST_IDLE) || frame_end);

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= wr_en && full;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock     (clock),
    .init_flag (init_flag),
    .clear     (pop),
    .run       (busy_q),
    .tick      (tick)
  );

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= LINE_IDLE;
      busy_q     <= 1'b0;
    end else if (pop) begin
      state_q  <= ST_START;
      shift_q  <= head;
      parity_q <= uart_even_parity(head);
      tx_q     <= LINE_START;
      busy_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q   <= LINE_IDLE;
          busy_q <= 1'b0;
        end
        ST_START: begin
          if (tick) begin
            state_q   <= ST_DATA;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx_q == BIT_LAST) begin
              state_q <= ST_PARITY;
              tx_q    <= parity_q;
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q    <= ST_STOP;
            tx_q       <= LINE_IDLE;
            stop_idx_q <= 1'b0;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_idx_q == STOP_LAST) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= LINE_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: instance A (4 clocks/bit, depth 4, one stop bit)
// and instance B (4 clocks/bit, depth 4, two stop bits).
module tb_uart_frame_tx;

  localparam int C = 4;
  localparam int D = 4;
  localparam int FL1 = 11 * C;
  localparam int FL2 = 12 * C;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       init_flag;
  logic       wr_en_a, enable_a, wr_en_b, enable_b;
  logic [7:0] wr_data_a, wr_data_b;
  logic       tx_a, busy_a, full_a, empty_a, overflow_a, frame_done_a;
  logic       tx_b, busy_b, full_b, empty_b, overflow_b, frame_done_b;
  logic [2:0] level_a, level_b;

  uart_frame_tx #(.CLKS_PER_BIT(C), .DEPTH(D), .STOP_BITS(1)) dut_a (
    .clock(clock), .init_flag(init_flag), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .enable(enable_a), .tx(tx_a), .busy(busy_a), .full(full_a), .empty(empty_a),
    .level(level_a), .overflow(overflow_a), .frame_done(frame_done_a)
  );

  uart_frame_tx #(.CLKS_PER_BIT(C), .DEPTH(D), .STOP_BITS(2)) dut_b (
    .clock(clock), .init_flag(init_flag), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .enable(enable_b), .tx(tx_b), .busy(busy_b), .full(full_b), .empty(empty_b),
    .level(level_b), .overflow(overflow_b), .frame_done(frame_done_b)
  );

  int checks = 0;
  int errors = 0;

  logic cap_tx   [0:299];
  logic cap_busy [0:299];
  logic cap_done [0:299];
  logic [7:0] exp_q [$];

  // Reference: bit j of a frame carrying byte d (j=0 start, 1..8 data LSB
  // first, 9 parity chosen so the ones count is even, beyond that stop bits).
  function automatic logic model_bit(input logic [7:0] d, input int j);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (j == 9) return (ones % 2) == 1;
    return 1'b1;
  endfunction

  // Waits (bounded) for tx to be low at a falling edge, then records n cycles.
  task automatic capture(input bit sel, input int n, output int waited);
    waited = 0;
    while (((sel ? tx_b : tx_a) !== 1'b0) && waited < 60) begin
      @(negedge clock);
      waited++;
    end
    for (int k = 0; k < n; k++) begin
      cap_tx[k]   = sel ? tx_b : tx_a;
      cap_busy[k] = sel ? busy_b : busy_a;
      cap_done[k] = sel ? frame_done_b : frame_done_a;
      if (k < n - 1) @(negedge clock);
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    wr_en_a = 1'b1;
    wr_data_a = d;
    @(negedge clock);
    wr_en_a = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (full_a !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full_a); end
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty_a); end
    checks++; if (level_a !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level_a); end
    checks++; if (overflow_a !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow_a); end
    checks++; if (frame_done_a !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done_a); end
    checks++; if (tx_b !== 1'b1) begin errors++; $display("FAIL reset_tx_b got %b want 1", tx_b); end
  endtask

  task automatic test_frame_a5;
    int w, dn;
    enable_a = 1'b1;
    push_a(8'hA5);
    capture(1'b0, FL1 + 2, w);
    checks++; if (w != 1) begin errors++; $display("FAIL a5_latency waited %0d want 1", w); end
    dn = 0;
    for (int k = 0; k < FL1 + 2; k++) dn += int'(cap_done[k]);
    for (int k = 0; k < FL1; k++) begin
      checks++;
      if (cap_tx[k] !== model_bit(8'hA5, k / C)) begin
        errors++; $display("FAIL a5_tx cycle %0d got %b want %b", k, cap_tx[k], model_bit(8'hA5, k / C));
      end
      checks++;
      if (cap_busy[k] !== 1'b1) begin errors++; $display("FAIL a5_busy cycle %0d got %b want 1", k, cap_busy[k]); end
    end
    checks++; if (cap_busy[FL1] !== 1'b0) begin errors++; $display("FAIL a5_busy_end got %b want 0", cap_busy[FL1]); end
    checks++; if (cap_tx[FL1] !== 1'b1) begin errors++; $display("FAIL a5_idle_tx got %b want 1", cap_tx[FL1]); end
    checks++; if (dn != 1) begin errors++; $display("FAIL a5_done_count got %0d want 1", dn); end
    checks++; if (cap_done[FL1-1] !== 1'b1) begin errors++; $display("FAIL a5_done_pos got %b want 1", cap_done[FL1-1]); end
  endtask

  task automatic test_parity;
    int w, ones;
    logic [7:0] d;
    enable_a = 1'b1;
    for (int t = 0; t < 5; t++) begin
      d = (t == 0) ? 8'h07 : 8'($urandom);
      push_a(d);
      capture(1'b0, FL1 + 1, w);
      checks++; if (w != 1) begin errors++; $display("FAIL par_latency byte %h waited %0d want 1", d, w); end
      for (int k = 0; k < FL1; k++) begin
        checks++;
        if (cap_tx[k] !== model_bit(d, k / C)) begin
          errors++; $display("FAIL par_tx byte %h cycle %0d got %b want %b", d, k, cap_tx[k], model_bit(d, k / C));
        end
      end
      ones = 0;
      for (int j = 1; j <= 9; j++) ones += int'(cap_tx[j*C + C/2]);
      checks++; if ((ones % 2) != 0) begin errors++; $display("FAIL par_even byte %h ones %0d want even", d, ones); end
      if (t == 0) begin
        checks++; if (cap_tx[9*C + 1] !== 1'b1) begin errors++; $display("FAIL par_07_bit got %b want 1", cap_tx[9*C + 1]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int w, dn;
    logic [7:0] d;
    enable_a = 1'b1;
    wr_en_a = 1'b1; wr_data_a = 8'h55;
    @(negedge clock);
    wr_data_a = 8'hFF;
    @(negedge clock);
    wr_en_a = 1'b0;
    checks++; if (level_a !== 3'd1) begin errors++; $display("FAIL b2b_level_pushpop got %0d want 1", level_a); end
    capture(1'b0, 2*FL1 + 2, w);
    checks++; if (w != 0) begin errors++; $display("FAIL b2b_latency waited %0d want 0", w); end
    dn = 0;
    for (int k = 0; k < 2*FL1 + 2; k++) dn += int'(cap_done[k]);
    for (int k = 0; k < 2*FL1; k++) begin
      d = (k < FL1) ? 8'h55 : 8'hFF;
      checks++;
      if (cap_tx[k] !== model_bit(d, (k % FL1) / C)) begin
        errors++; $display("FAIL b2b_tx cycle %0d got %b want %b", k, cap_tx[k], model_bit(d, (k % FL1) / C));
      end
      checks++;
      if (cap_busy[k] !== 1'b1) begin errors++; $display("FAIL b2b_busy cycle %0d got %b want 1", k, cap_busy[k]); end
    end
    checks++; if (cap_busy[2*FL1] !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", cap_busy[2*FL1]); end
    checks++; if (dn != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", dn); end
    checks++; if (cap_tx[FL1 + 9*C + 1] !== 1'b0) begin errors++; $display("FAIL b2b_parity2 got %b want 0", cap_tx[FL1 + 9*C + 1]); end
  endtask

  task automatic test_fifo_full;
    int w, ov_seen, drops, tx_bad;
    logic [7:0] d;
    enable_a = 1'b0;
    exp_q.delete();
    ov_seen = 0; drops = 0; tx_bad = 0;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      wr_en_a = 1'b1; wr_data_a = d;
      if (exp_q.size() < D) exp_q.push_back(d); else drops++;
      @(negedge clock);
      ov_seen += int'(overflow_a);
      if (tx_a !== 1'b1) tx_bad++;
    end
    wr_en_a = 1'b0;
    @(negedge clock);
    ov_seen += int'(overflow_a);
    checks++; if (ov_seen != drops) begin errors++; $display("FAIL full_overflow_count got %0d want %0d", ov_seen, drops); end
    checks++; if (tx_bad != 0) begin errors++; $display("FAIL full_tx_idle got %0d low samples want 0", tx_bad); end
    checks++; if (level_a !== 3'(exp_q.size())) begin errors++; $display("FAIL full_level got %0d want %0d", level_a, exp_q.size()); end
    checks++; if (full_a !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", full_a); end
    // Enable and push on the same edge: the pop must not make room.
    enable_a = 1'b1; wr_en_a = 1'b1; wr_data_a = 8'($urandom);
    @(negedge clock);
    wr_en_a = 1'b0;
    checks++; if (overflow_a !== 1'b1) begin errors++; $display("FAIL full_pushpop_overflow got %b want 1", overflow_a); end
    checks++; if (level_a !== 3'(D - 1)) begin errors++; $display("FAIL full_pushpop_level got %0d want %0d", level_a, D - 1); end
    capture(1'b0, D*FL1 + 2, w);
    checks++; if (w != 0) begin errors++; $display("FAIL full_latency waited %0d want 0", w); end
    for (int k = 0; k < D*FL1; k++) begin
      d = exp_q[k / FL1];
      checks++;
      if (cap_tx[k] !== model_bit(d, (k % FL1) / C)) begin
        errors++; $display("FAIL full_tx cycle %0d got %b want %b", k, cap_tx[k], model_bit(d, (k % FL1) / C));
      end
    end
    checks++; if (cap_busy[D*FL1] !== 1'b0) begin errors++; $display("FAIL full_busy_end got %b want 0", cap_busy[D*FL1]); end
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL full_drain_empty got %b want 1", empty_a); end
    checks++; if (level_a !== 3'd0) begin errors++; $display("FAIL full_drain_level got %0d want 0", level_a); end
  endtask

  task automatic test_enable_midframe;
    int w, bad;
    logic [7:0] x, y;
    x = 8'($urandom); y = 8'($urandom);
    enable_a = 1'b1;
    push_a(x);
    push_a(y);
    enable_a = 1'b0;
    capture(1'b0, FL1, w);
    checks++; if (w != 0) begin errors++; $display("FAIL en_latency waited %0d want 0", w); end
    bad = 0;
    for (int k = 0; k < FL1; k++) if (cap_tx[k] !== model_bit(x, k / C)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL en_first_frame got %0d wrong cycles want 0", bad); end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL en_held_idle got %0d active cycles want 0", bad); end
    checks++; if (level_a !== 3'd1) begin errors++; $display("FAIL en_held_level got %0d want 1", level_a); end
    enable_a = 1'b1;
    capture(1'b0, FL1 + 1, w);
    checks++; if (w != 1) begin errors++; $display("FAIL en_resume_latency waited %0d want 1", w); end
    bad = 0;
    for (int k = 0; k < FL1; k++) if (cap_tx[k] !== model_bit(y, k / C)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL en_second_frame got %0d wrong cycles want 0", bad); end
  endtask

  task automatic test_reset_midframe;
    int bad;
    enable_a = 1'b1;
    push_a(8'h00);
    push_a(8'h3C);
    push_a(8'hC3);
    repeat (10) @(negedge clock);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %b want 1", busy_a); end
    #2 init_flag = 1'b0;
    #1;
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got %b want 1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy_a); end
    checks++; if (level_a !== 3'd0) begin errors++; $display("FAIL rst_mid_level got %0d want 0", level_a); end
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL rst_mid_empty got %b want 1", empty_a); end
    @(negedge clock);
    init_flag = 1'b1;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_residual got %0d active cycles want 0", bad); end
  endtask

  task automatic test_two_stop;
    int w, dn;
    enable_b = 1'b1;
    wr_en_b = 1'b1; wr_data_b = 8'h00;
    @(negedge clock);
    wr_en_b = 1'b0;
    capture(1'b1, FL2 + 2, w);
    checks++; if (w != 1) begin errors++; $display("FAIL stop2_latency waited %0d want 1", w); end
    dn = 0;
    for (int k = 0; k < FL2 + 2; k++) dn += int'(cap_done[k]);
    for (int k = 0; k < FL2; k++) begin
      checks++;
      if (cap_tx[k] !== model_bit(8'h00, k / C)) begin
        errors++; $display("FAIL stop2_tx cycle %0d got %b want %b", k, cap_tx[k], model_bit(8'h00, k / C));
      end
      checks++;
      if (cap_busy[k] !== 1'b1) begin errors++; $display("FAIL stop2_busy cycle %0d got %b want 1", k, cap_busy[k]); end
    end
    checks++; if (cap_busy[FL2] !== 1'b0) begin errors++; $display("FAIL stop2_busy_end got %b want 0", cap_busy[FL2]); end
    checks++; if (dn != 1) begin errors++; $display("FAIL stop2_done_count got %0d want 1", dn); end
    checks++; if (cap_done[FL2-1] !== 1'b1) begin errors++; $display("FAIL stop2_done_pos got %b want 1", cap_done[FL2-1]); end
    checks++; if (empty_b !== 1'b1 || level_b !== 3'd0) begin errors++; $display("FAIL stop2_empty got empty=%b level=%0d want 1/0", empty_b, level_b); end
    checks++; if (full_b !== 1'b0 || overflow_b !== 1'b0) begin errors++; $display("FAIL stop2_flags got full=%b ovf=%b want 0/0", full_b, overflow_b); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    init_flag = 1'b0;
    wr_en_a = 1'b0; wr_data_a = 8'h00; enable_a = 1'b0;
    wr_en_b = 1'b0; wr_data_b = 8'h00; enable_b = 1'b0;
    repeat (3) @(negedge clock);
    test_reset;
    init_flag = 1'b1;
    repeat (2) @(negedge clock);
    test_frame_a5;
    test_parity;
    test_back_to_back;
    test_fifo_full;
    test_enable_midframe;
    test_reset_midframe;
    test_two_stop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
